// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of CPU, host and memory-side signals around the data memory arbiter.
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: accepts requests, drives grants and the memory command.
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output host_gnt, host_rvalid, host_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_mem_arbiter_wait_counter.sv
// Saturating count of consecutive host losses; at_limit forces the next host win.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [3:0] count;

  assign at_limit = (count == 4'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU load/store port and the host port,
// CPU first with a bounded wait for the host; one memory command per grant.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input logic                clk,
  input logic                reset_n,
  data_mem_arbiter_if.master bus
);

  state_t            state;
  logic              owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cpu_rd_pend;
  logic              cpu_gnt_q;
  logic              host_gnt_q;
  logic              cpu_rvalid_q;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              any_req;
  logic              host_wins;
  logic              arb_now;
  logic              at_limit;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The host only beats a requesting CPU once it has lost MAX_WAIT times in a row.
  assign any_req   = bus.cpu_req | bus.host_req;
  assign host_wins = bus.host_req & (~bus.cpu_req | at_limit);
  assign arb_now   = (state == IDLE) & any_req;
  assign sel_we    = host_wins ? bus.host_we    : bus.cpu_we;
  assign sel_addr  = host_wins ? bus.host_addr  : bus.cpu_addr;
  assign sel_wdata = host_wins ? bus.host_wdata : bus.cpu_wdata;

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (arb_now & bus.host_req & ~host_wins),
    .clr      (arb_now & host_wins),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= REQ_CPU;
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      cmd_wdata     <= '0;
      cpu_rd_pend   <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner       <= host_wins ? REQ_HOST : REQ_CPU;
            cmd_we      <= sel_we;
            cmd_addr    <= sel_addr;
            cmd_wdata   <= sel_wdata;
            cpu_gnt_q   <= ~host_wins;
            host_gnt_q  <= host_wins;
            mem_read_q  <= ~sel_we;
            mem_write_q <= sel_we;
            cpu_rd_pend <= ~host_wins & ~bus.cpu_we;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= cmd_we ? IDLE : RESP;
        end
        RESP: begin
          if (owner == REQ_HOST) begin
            host_rdata_q  <= bus.mem_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            cpu_rdata_q  <= bus.mem_rdata;
            cpu_rvalid_q <= 1'b1;
            cpu_rd_pend  <= 1'b0;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_gnt     = cpu_gnt_q;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = cmd_addr;
  assign bus.mem_wdata   = cmd_wdata;
  assign bus.cpu_stall   = (bus.cpu_req & ~cpu_gnt_q) | cpu_rd_pend;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed bench for data_mem_arbiter against a transaction-timed reference model.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;
  localparam int DRAIN_LIMIT = 3000;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miscmp = 0;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Simple memory behind the arbiter: one-cycle read latency, junk when not reading.
  bit [15:0] env_mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_write) env_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read) bus.mem_rdata <= env_mem[bus.mem_addr];
    else              bus.mem_rdata <= 16'($urandom);
  end

  cmd_t cq[$];
  cmd_t hq[$];
  bit   c_pop = 1'b0;
  bit   h_pop = 1'b0;
  bit   host_toggle = 1'b0;

  task automatic applyStimulus(input bit host, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    cmd_t c;
    c.we = we;
    c.addr = addr;
    c.wdata = wdata;
    if (host) hq.push_back(c);
    else      cq.push_back(c);
  endtask

  // Requesters: hold a command until its grant, move on the cycle after.
  initial begin
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (c_pop && cq.size() > 0) void'(cq.pop_front());
      if (h_pop && hq.size() > 0) void'(hq.pop_front());
      c_pop = bus.cpu_gnt;
      h_pop = bus.host_gnt;
      if (cq.size() > 0) begin
        bus.cpu_req = 1'b1;
        bus.cpu_we = cq[0].we;
        bus.cpu_addr = cq[0].addr;
        bus.cpu_wdata = cq[0].wdata;
      end else begin
        bus.cpu_req = 1'b0;
      end
      if (hq.size() > 0) begin
        bus.host_req = host_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.host_we = hq[0].we;
        bus.host_addr = hq[0].addr;
        bus.host_wdata = hq[0].wdata;
      end else begin
        bus.host_req = 1'b0;
      end
    end
  end

  // Reference model: schedules per-cycle expectations from each arbitration decision.
  bit          e_cgnt [8];
  bit          e_hgnt [8];
  bit          e_rd   [8];
  bit          e_wr   [8];
  bit          e_crv  [8];
  bit          e_hrv  [8];
  logic [15:0] e_addr [8];
  logic [15:0] e_wdata[8];
  logic [15:0] e_rdata[8];
  bit   [15:0] ref_mem [0:65535];
  logic [15:0] m_addr = '0, m_wdata = '0, m_crdata = '0, m_hrdata = '0;
  int          free_at = 0;
  int          waits = 0;
  int          pend_lo = 1;
  int          pend_hi = 0;
  bit          gnt_log[$];
  logic [15:0] crd_log[$];

  always @(negedge clk) begin : model
    int s;
    bit hw;
    bit we;
    bit exp_stall;
    logic [15:0] a;
    logic [15:0] d;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        e_cgnt[i] = 0; e_hgnt[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_crv[i] = 0; e_hrv[i] = 0;
      end
      m_addr = '0; m_wdata = '0; m_crdata = '0; m_hrdata = '0;
      free_at = 0; waits = 0; pend_lo = 1; pend_hi = 0;
    end
    s = cyc % 8;
    if (e_rd[s] || e_wr[s]) begin
      m_addr = e_addr[s];
      m_wdata = e_wdata[s];
    end
    if (e_crv[s]) m_crdata = e_rdata[s];
    if (e_hrv[s]) m_hrdata = e_rdata[s];
    exp_stall = (bus.cpu_req && !e_cgnt[s]) || (cyc >= pend_lo && cyc <= pend_hi);

    checkOutput("cpu_gnt",     32'(bus.cpu_gnt),     32'(e_cgnt[s]));
    checkOutput("host_gnt",    32'(bus.host_gnt),    32'(e_hgnt[s]));
    checkOutput("mem_read",    32'(bus.mem_read),    32'(e_rd[s]));
    checkOutput("mem_write",   32'(bus.mem_write),   32'(e_wr[s]));
    checkOutput("rd_wr_excl",  32'(bus.mem_read & bus.mem_write), 0);
    checkOutput("mem_addr",    32'(bus.mem_addr),    32'(m_addr));
    checkOutput("mem_wdata",   32'(bus.mem_wdata),   32'(m_wdata));
    checkOutput("cpu_rvalid",  32'(bus.cpu_rvalid),  32'(e_crv[s]));
    checkOutput("host_rvalid", 32'(bus.host_rvalid), 32'(e_hrv[s]));
    checkOutput("cpu_rdata",   32'(bus.cpu_rdata),   32'(m_crdata));
    checkOutput("host_rdata",  32'(bus.host_rdata),  32'(m_hrdata));
    checkOutput("cpu_stall",   32'(bus.cpu_stall),   32'(exp_stall));

    if (bus.cpu_gnt)    gnt_log.push_back(REQ_CPU);
    if (bus.host_gnt)   gnt_log.push_back(REQ_HOST);
    if (bus.cpu_rvalid) crd_log.push_back(bus.cpu_rdata);

    e_cgnt[s] = 0; e_hgnt[s] = 0; e_rd[s] = 0; e_wr[s] = 0; e_crv[s] = 0; e_hrv[s] = 0;

    if (reset_n && cyc >= free_at && (bus.cpu_req || bus.host_req)) begin
      hw = bus.host_req && (!bus.cpu_req || waits == MAX_WAIT);
      if (hw) waits = 0;
      else if (bus.host_req && waits < MAX_WAIT) waits++;
      we = hw ? bus.host_we : bus.cpu_we;
      a  = hw ? bus.host_addr : bus.cpu_addr;
      d  = hw ? bus.host_wdata : bus.cpu_wdata;
      s = (cyc + 1) % 8;
      e_cgnt[s] = !hw; e_hgnt[s] = hw; e_rd[s] = !we; e_wr[s] = we;
      e_addr[s] = a; e_wdata[s] = d;
      if (we) begin
        ref_mem[a] = d;
        free_at = cyc + 2;
      end else begin
        s = (cyc + 3) % 8;
        e_crv[s] = !hw; e_hrv[s] = hw; e_rdata[s] = ref_mem[a];
        free_at = cyc + 3;
        if (!hw) begin
          pend_lo = cyc + 1;
          pend_hi = cyc + 2;
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((cq.size() != 0 || hq.size() != 0 || cyc <= free_at) && t < DRAIN_LIMIT) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    checkOutput("drain_timeout", 32'(t >= DRAIN_LIMIT), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] ra;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    $display("[TB] reset released");

    // CPU write then read-back of one word.
    applyStimulus(0, 1, 16'h0005, 16'h1234);
    drain();
    crd_log.delete();
    applyStimulus(0, 0, 16'h0005, 16'h0000);
    drain();
    checkOutput("rd_0005_count", 32'(crd_log.size()), 1);
    if (crd_log.size() > 0) checkOutput("rd_0005_data", 32'(crd_log[0]), 32'h1234);

    // Both ports reading continuously: CPU x4 then host x1.
    gnt_log.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 16'(16'h0100 + i), 16'($urandom));
      applyStimulus(1, 0, 16'(16'h0200 + i), 16'($urandom));
    end
    drain();
    checkOutput("order_count", 32'(gnt_log.size()), 20);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("order%0d", i), (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hDEAD,
                  (i % 5 == 4) ? 32'(REQ_HOST) : 32'(REQ_CPU));

    // Host write burst, CPU reads back.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 16'(16'h0010 + i), 16'(16'hA000 + i));
    drain();
    crd_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'(16'h0010 + i), 16'h0000);
    drain();
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("burst_rd%0d", i), (i < crd_log.size()) ? 32'(crd_log[i]) : 32'hDEAD,
                  32'(16'hA000 + i));

    // Reset during the RESP cycle of a CPU read, then a fresh read.
    applyStimulus(0, 0, 16'h0005, 16'h0000);
    for (int i = 0; i < 20 && !bus.cpu_gnt; i++) @(negedge clk);
    checkOutput("rst_gnt_seen", 32'(bus.cpu_gnt), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    crd_log.delete();
    applyStimulus(0, 0, 16'h0010, 16'h0000);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    drain();
    checkOutput("post_rst_count", 32'(crd_log.size()), 1);
    if (crd_log.size() > 0) checkOutput("post_rst_data", 32'(crd_log[0]), 32'hA000);

    // Random mixed traffic, small address pool to exercise read-after-write.
    for (int i = 0; i < 40; i++) begin
      for (int h = 0; h < 2; h++) begin
        ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        applyStimulus(h[0], 1'($urandom_range(0, 1)), ra, 16'($urandom));
      end
    end
    drain();

    // Host request toggling while the arbiter is busy.
    host_toggle = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
      applyStimulus(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
    end
    drain();
    host_toggle = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port 16-bit data memory between the processor's load/store port and a host loader/debug port. It accepts requests, arbitrates with CPU priority plus a bounded-wait guarantee for the host, and issues exactly one memory command per grant. It returns read data with a fixed latency and drives a stall to the processor while a CPU access is pending. It sits between the processor datapath, the host interface and the `data_memory` instance.

## Interface
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: data width.
- `MAX_WAIT`, 4: consecutive host losses before the host is forced to win (1..15).

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request, held until `cpu_gnt`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_gnt` out 1: one-cycle acceptance pulse.
- `cpu_rvalid` out 1: one-cycle read-data-valid pulse.
- `cpu_rdata` out DATA_W: read data, valid with `cpu_rvalid`.
- `cpu_stall` out 1: processor must hold PC and instruction.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same as the `cpu_*` equivalents.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `mem_read`.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- **IDLE**:
  - If any request is present, choose a winner.
  - Latch the winner's id, we, addr and wdata.
  - Pulse that requester's `gnt` in the next cycle.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- **Winner selection**:
  - The CPU wins when `cpu_req` is high, unless `wait_cnt == MAX_WAIT` and `host_req` is high; then the host wins.
  - The host wins when it is the only requester.
- **wait_cnt** (4-bit):
  - Increments on each IDLE arbitration where `host_req` is high and the CPU wins.
  - Clears when the host wins.
  - Holds otherwise.
  - Saturates at `MAX_WAIT`.
- **ISSUE**:
  - Drive `mem_read` or `mem_write`, `mem_addr` and `mem_wdata` from the latched command for exactly one cycle.
  - A write then goes to IDLE; a read goes to RESP.
- **RESP**:
  - Capture `mem_rdata` into the owner's rdata register.
  - Set the owner's `rvalid` for the following cycle.
  - Go to IDLE.
- **Memory outputs**:
  - `mem_read`/`mem_write` are 0 outside ISSUE and are never both high.
  - `mem_addr`/`mem_wdata` hold their latched values between accesses.
- **cpu_stall** = (`cpu_req` & ~`cpu_gnt`) | `cpu_rd_pend`.
  - `cpu_rd_pend` sets on a CPU read grant and clears in the `cpu_rvalid` cycle.
  - `cpu_stall` is combinational in `cpu_req`.
- **Requester rules**:
  - Fields must stay stable while `req` is high.
  - After `gnt`, the requester deasserts `req` or presents a new command in the next cycle.
  - Requests seen outside IDLE are ignored until IDLE.

## Timing
- Reset values:
  - State is IDLE; `wait_cnt`, `cpu_rd_pend` and the latched command are 0.
  - `cpu_gnt`, `host_gnt`, `cpu_rvalid`, `host_rvalid`, `mem_read` and `mem_write` are 0.
  - `cpu_rdata`, `host_rdata`, `mem_addr` and `mem_wdata` are 0.
  - `cpu_stall` follows `cpu_req`.
- Request present in IDLE at cycle N:
  - `gnt` and the memory command are both in cycle N+1.
  - For a read, data is captured at the end of N+2 and `rvalid`/`rdata` appear in cycle N+3.
- Throughput:
  - Back-to-back writes: one grant every 2 cycles.
  - Back-to-back reads: one grant every 3 cycles.
  - `rvalid` of one read coincides with IDLE arbitration of the next.
- Simultaneous requests: a single grant per arbitration; the loser stays pending and no request is ever dropped.
- Host worst-case wait is `MAX_WAIT` CPU grants.
- `reset_n` low mid-transaction:
  - Immediately returns to reset values.
  - The pending read is abandoned; no `rvalid` follows.
  - Any write already in its ISSUE cycle is unspecified at memory.
- Address and data wrap are not applicable; addresses pass through unchanged.

## Structure
- `mem_arb_pkg` holds:
  - the state typedef (IDLE/ISSUE/RESP);
  - the requester-id constants `REQ_CPU = 1'b0` and `REQ_HOST = 1'b1`;
  - the default widths.
- One sub-module, `arb_wait_counter`: saturating counter with inc/clr inputs and an `at_limit` output, parameterised by `MAX_WAIT`.
- Priority select, FSM and output registers stay in `data_mem_arbiter`.

## Test plan
- **CPU write** of addr 0x0005 = 0x1234, then **CPU read** of 0x0005:
  - `cpu_gnt` at N+1, with `mem_write`=1 and `mem_addr`=0x0005 at N+1.
  - For the read, `cpu_rvalid`=1 with `cpu_rdata`=0x1234 exactly 3 cycles after its request is seen in IDLE.
  - `cpu_stall` is high until the `rvalid` cycle.
- **Both requesting continuously** (reads), `MAX_WAIT`=4: the grant order is CPU ×4, host ×1, repeating; `wait_cnt` returns to 0 after each host grant.
- **Host-only burst** of writes 0x0010..0x0013 with data 0xA000..0xA003, then CPU reads back:
  - `host_gnt` every 2 cycles.
  - Readback returns 0xA000..0xA003 in order.
- **`reset_n` pulsed low in RESP** of a CPU read:
  - No `cpu_rvalid` follows and all outputs are 0.
  - `cpu_stall` equals `cpu_req`; a fresh request afterwards completes normally.
- **Requests change while in ISSUE/RESP** (host_req toggled): no grant until IDLE, `mem_read`/`mem_write` are never both high, and exactly one `gnt` occurs per memory command.
